lag_link_channel_mon: RTL
=========================

# lag_link_channel_mon

Parametrised inter-router link for LAG mesh and torus networks. It replaces the plain pipelined channel between adjacent routers and carries `NPL` physical lanes of `flit_t` plus the forward `chan_cntrl_t` word through `STAGES` register stages. It also performs in-hardware link-utilisation accounting, both cumulative and windowed, and per-lane flit-id sequence checking, so these no longer depend on simulation-only `$display`/`$finish` checks.

## Interface
- `NPL`, 4, physical lanes per link (1..8)
- `STAGES`, 1, register stages on data and control (0..8; 0 = combinational passthrough)
- `CNT_W`, 32, width of the cumulative utilisation counter per lane
- `WIN_LOG2`, 10, window length is 2^WIN_LOG2 cycles (2..16)
- `ID_W`, 16, width of `debug.flit_id` compared by the checker

- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `data_in`  in  flit_t[NPL]  flits from upstream router output port
- `ctrl_in`  in  chan_cntrl_t  credit/control word from upstream router
- `data_out`  out  flit_t[NPL]  `data_in` delayed `STAGES` cycles
- `ctrl_out`  out  chan_cntrl_t  `ctrl_in` delayed `STAGES` cycles
- `clr_stats`  in  1  synchronous clear of statistics and error capture
- `util_cnt`  out  CNT_W[NPL]  cumulative valid flits per lane, saturating
- `win_util`  out  (WIN_LOG2+1)[NPL]  valid flits per lane in last complete window
- `win_done`  out  1  one-cycle pulse when `win_util` updates
- `seq_err`  out  NPL  sticky per-lane sequence error
- `err_valid`  out  1  first-error capture holds data
- `err_lane`  out  clog2(NPL) (min 1)  lane of first error
- `err_got`, `err_exp`  out  ID_W each  received and expected id of first error

## Operation
- Pipeline: `STAGES` flop banks on the full `flit_t[NPL]` and `chan_cntrl_t`. No stall and no backpressure: flow control is credit-based upstream.
- Monitors sample `data_in` at each rising edge, on the upstream side. `STAGES` does not affect monitor results.
- A lane is active in a cycle if `data_in[c].control.valid` is 1.
- `util_cnt[c]`: +1 per active cycle. Holds at 2^CNT_W−1 once saturated.
- Window: free-running cycle counter `wcyc` (WIN_LOG2 bits) and a per-lane accumulator `acc[c]`.
  - When `wcyc` = all-ones: `win_util[c]` ← `acc[c]` + active; `acc[c]` ← 0; `win_done` ← 1.
  - Otherwise: `acc[c]` += active; `win_done` ← 0.
  - The maximum count of 2^WIN_LOG2 fits in WIN_LOG2+1 bits.
- Sequence checker per lane: `exp[c]` resets to 1. On each active cycle:
  - If `flit_id` ≠ `exp[c]`: set `seq_err[c]`. If `err_valid` = 0, capture lane, got and exp, and set `err_valid`.
  - Next `exp[c]`: 1 if `control.tail`, else `flit_id`+1 mod 2^ID_W (resync on the received id, so a single fault is not cascaded).
  - Simultaneous errors on several lanes: the lowest lane index is captured.
- `clr_stats` = 1:
  - Zeroes `util_cnt`, `acc`, `win_util`, `wcyc`, `seq_err`, `err_*` and `win_done`.
  - Has priority over any same-cycle increment or capture.
  - Does not touch `exp[c]` or pipeline contents.

## Timing
- Reset (`rst_n` low, asynchronous, mid-traffic included):
  - All pipeline flops, and therefore `data_out` and `ctrl_out` when `STAGES` ≥ 1, go to 0 immediately.
  - All statistics and error outputs are 0; `exp[c]` = 1.
  - With `STAGES` = 0, `data_out` follows `data_in` regardless of reset.
- Latency: `data_out`/`ctrl_out` at cycle n+`STAGES` equals the input at cycle n; full throughput, one flit per lane per cycle.
- `util_cnt`, `seq_err` and `err_*` reflect a flit sampled at edge n from edge n onward (registered, visible in cycle n+1).
- First window closes at the 2^WIN_LOG2-th edge after reset release or clear. `win_done` is high for exactly the following cycle, coincident with the new `win_util`.
- Counter wrap: `wcyc` wraps to 0 after the window edge. `util_cnt` never wraps. The `exp` increment wraps modulo 2^ID_W.

## Test plan
- `STAGES`=2, `NPL`=4: lane 1 valid, id 1, tail, at cycle 5; `ctrl_in.credits` pattern 0101 at cycle 5 → `data_out[1]` identical to the input at cycle 7, other lanes 0, `ctrl_out` = 0101 at cycle 7. Repeat with `STAGES`=0 → same-cycle passthrough.
- Lane 0 ids 1, 2, 3(tail), 1, 3 → no error until id 3 on the 5th flit. Then `seq_err`=0001, `err_lane`=0, `err_got`=3, `err_exp`=2. A following id 4 raises no new error and leaves the capture unchanged.
- `WIN_LOG2`=4: lane 2 valid continuously for 40 cycles from reset release → `win_done` pulses after the 16th and 32nd edges, `win_util[2]`=16 each time, other lanes 0; `util_cnt[2]`=40.
- `CNT_W`=4: 20 valid flits on lane 3 → `util_cnt[3]`=15 and holds.
- `clr_stats` asserted in the same cycle as a valid flit with a bad id → `util_cnt`=0, `seq_err`=0 and `err_valid`=0 afterwards. The next in-sequence flit counts 1 with no error.
- `rst_n` dropped while 2 flits are in flight (`STAGES`=3) → `data_out` is 0 immediately. After release the flits are not delivered, counters are 0 and a flit with id 1 is accepted without error.

Source files
------------

// File: rtl/lag_link_channel_mon.sv
// ---------------------------------------------------------------------------
// lag_link_pkg / lag_link_channel_mon
//
// Inter-router link for LAG mesh/torus networks. Carries NPL lanes of flit_t
// plus the forward chan_cntrl_t word through STAGES register banks (0 =
// combinational passthrough) and monitors the upstream side of the link:
// cumulative and windowed utilisation per lane and per-lane flit-id
// sequence checking with first-error capture.
//
// Ports
//   clk_i         sole clock
//   rst_n_i       asynchronous active-low reset
//   data_in_i     flits from the upstream router output port
//   ctrl_in_i     credit/control word from the upstream router
//   data_out_o    data_in_i delayed STAGES cycles
//   ctrl_out_o    ctrl_in_i delayed STAGES cycles
//   clr_stats_i   synchronous clear of statistics and error capture
//   util_cnt_o    cumulative valid flits per lane, saturating
//   win_util_o    valid flits per lane in the last complete window
//   win_done_o    one-cycle pulse when win_util_o updates
//   seq_err_o     sticky per-lane sequence error
//   err_valid_o   first-error capture holds data
//   err_lane_o    lane of the first error
//   err_got_o     received id of the first error
//   err_exp_o     expected id of the first error
// ---------------------------------------------------------------------------
package lag_link_pkg;

  typedef struct packed {
    logic valid;
    logic head;
    logic tail;
  } flit_ctrl_t;

  typedef struct packed {
    logic [15:0] flit_id;
  } flit_dbg_t;

  typedef struct packed {
    flit_ctrl_t  control;
    flit_dbg_t   debug;
    logic [31:0] data;
  } flit_t;

  typedef struct packed {
    logic [3:0] credits;
  } chan_cntrl_t;

endpackage

module lag_link_channel_mon
  import lag_link_pkg::*;
#(
  parameter int NPL      = 4,
  parameter int STAGES   = 1,
  parameter int CNT_W    = 32,
  parameter int WIN_LOG2 = 10,
  parameter int ID_W     = 16,
  localparam int LANE_W  = (NPL > 1) ? $clog2(NPL) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  flit_t       [NPL-1:0]           data_in_i,
  input  chan_cntrl_t                     ctrl_in_i,
  output flit_t       [NPL-1:0]           data_out_o,
  output chan_cntrl_t                     ctrl_out_o,
  input  logic                            clr_stats_i,
  output logic        [NPL-1:0][CNT_W-1:0] util_cnt_o,
  output logic        [NPL-1:0][WIN_LOG2:0] win_util_o,
  output logic                            win_done_o,
  output logic        [NPL-1:0]           seq_err_o,
  output logic                            err_valid_o,
  output logic        [LANE_W-1:0]        err_lane_o,
  output logic        [ID_W-1:0]          err_got_o,
  output logic        [ID_W-1:0]          err_exp_o
);

  localparam int AW = WIN_LOG2 + 1;

  // ---------------- pipeline ----------------
  if (STAGES == 0) begin : g_pass
    assign data_out_o = data_in_i;
    assign ctrl_out_o = ctrl_in_i;
  end else begin : g_pipe
    flit_t [NPL-1:0] dpipe_q [STAGES];
    chan_cntrl_t     cpipe_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int s = 0; s < STAGES; s++) begin
          dpipe_q[s] <= '0;
          cpipe_q[s] <= '0;
        end
      end else begin
        dpipe_q[0] <= data_in_i;
        cpipe_q[0] <= ctrl_in_i;
        for (int s = 1; s < STAGES; s++) begin
          dpipe_q[s] <= dpipe_q[s-1];
          cpipe_q[s] <= cpipe_q[s-1];
        end
      end
    end

    assign data_out_o = dpipe_q[STAGES-1];
    assign ctrl_out_o = cpipe_q[STAGES-1];
  end

  // ---------------- monitors ----------------
  logic [WIN_LOG2-1:0]           wcyc_q, wcyc_d;
  logic [NPL-1:0][CNT_W-1:0]     util_q, util_d;
  logic [NPL-1:0][AW-1:0]        acc_q, acc_d;
  logic [NPL-1:0][AW-1:0]        win_q, win_d;
  logic [NPL-1:0][ID_W-1:0]      exp_q, exp_d;
  logic [NPL-1:0]                seq_q, seq_d;
  logic [NPL-1:0]                mism;
  logic                          win_done_q, win_done_d;
  logic                          errv_q, errv_d;
  logic [LANE_W-1:0]             elane_q, elane_d;
  logic [ID_W-1:0]               egot_q, egot_d;
  logic [ID_W-1:0]               eexp_q, eexp_d;
  logic                          win_end;

  assign win_end = &wcyc_q;

  always_comb begin
    wcyc_d     = wcyc_q + WIN_LOG2'(1);
    win_done_d = win_end;
    util_d     = util_q;
    acc_d      = acc_q;
    win_d      = win_q;
    exp_d      = exp_q;
    seq_d      = seq_q;
    mism       = '0;
    errv_d     = errv_q;
    elane_d    = elane_q;
    egot_d     = egot_q;
    eexp_d     = eexp_q;

    for (int c = 0; c < NPL; c++) begin
      if (data_in_i[c].control.valid) begin
        if (util_q[c] != '1) util_d[c] = util_q[c] + CNT_W'(1);
        mism[c] = (data_in_i[c].debug.flit_id[ID_W-1:0] != exp_q[c]);
        // Resync on the received id so one bad flit flags only once.
        exp_d[c] = data_in_i[c].control.tail ? ID_W'(1)
                                             : data_in_i[c].debug.flit_id[ID_W-1:0] + ID_W'(1);
      end
      if (win_end) begin
        win_d[c] = acc_q[c] + AW'(data_in_i[c].control.valid);
        acc_d[c] = '0;
      end else begin
        acc_d[c] = acc_q[c] + AW'(data_in_i[c].control.valid);
      end
      seq_d[c] = seq_q[c] | mism[c];
    end

    // Walk downward so the lowest erroring lane is the one left captured.
    if (!errv_q) begin
      for (int c = NPL-1; c >= 0; c--) begin
        if (mism[c]) begin
          errv_d  = 1'b1;
          elane_d = LANE_W'(c);
          egot_d  = data_in_i[c].debug.flit_id[ID_W-1:0];
          eexp_d  = exp_q[c];
        end
      end
    end

    // Clear wins over same-cycle updates; expected ids keep tracking traffic.
    if (clr_stats_i) begin
      wcyc_d     = '0;
      win_done_d = 1'b0;
      util_d     = '0;
      acc_d      = '0;
      win_d      = '0;
      seq_d      = '0;
      errv_d     = 1'b0;
      elane_d    = '0;
      egot_d     = '0;
      eexp_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wcyc_q     <= '0;
      win_done_q <= 1'b0;
      util_q     <= '0;
      acc_q      <= '0;
      win_q      <= '0;
      seq_q      <= '0;
      errv_q     <= 1'b0;
      elane_q    <= '0;
      egot_q     <= '0;
      eexp_q     <= '0;
      for (int c = 0; c < NPL; c++) exp_q[c] <= ID_W'(1);
    end else begin
      wcyc_q     <= wcyc_d;
      win_done_q <= win_done_d;
      util_q     <= util_d;
      acc_q      <= acc_d;
      win_q      <= win_d;
      seq_q      <= seq_d;
      errv_q     <= errv_d;
      elane_q    <= elane_d;
      egot_q     <= egot_d;
      eexp_q     <= eexp_d;
      exp_q      <= exp_d;
    end
  end

  assign util_cnt_o  = util_q;
  assign win_util_o  = win_q;
  assign win_done_o  = win_done_q;
  assign seq_err_o   = seq_q;
  assign err_valid_o = errv_q;
  assign err_lane_o  = elane_q;
  assign err_got_o   = egot_q;
  assign err_exp_o   = eexp_q;

endmodule
